// File: rtl/xbar_slot_arbiter.sv
// Per-slot crossbar arbiter: round-robin per output, then issues grants one per cycle.
// Optional arbitration-loss statistics counter enabled by defining XBAR_ARB_STATS_EN.
module xbar_slot_arbiter #(
  parameter int PORTS = 4,
  parameter int SLOTS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               slot_start,
  input  logic [$clog2(SLOTS)-1:0]           running_slot,
  input  logic [PORTS-1:0]                   req,
  input  logic [PORTS*$clog2(PORTS)-1:0]     req_dest,
  output logic [PORTS-1:0]                   grant,
  output logic [$clog2(PORTS*SLOTS)-1:0]     mux_sel,
  output logic [$clog2(PORTS)-1:0]           sw2op_wcs,
  output logic                               sw_valid,
  output logic                               swdone,
  output logic                               busy,
  output logic                               err_overrun,
  output logic [15:0]                        conflict_cnt
);

  localparam int DW = $clog2(PORTS);
  localparam int SW = $clog2(SLOTS);
  localparam int MW = $clog2(PORTS*SLOTS);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, DONE} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   k_q;
  logic [SW-1:0]   slot_q;
  logic [PORTS-1:0] req_q;
  logic [DW-1:0]   dest_q [PORTS];
  logic [DW-1:0]   ptr_q  [PORTS];
  logic [DW-1:0]   ptr_n  [PORTS];
  logic [PORTS-1:0] grant_n;
  logic [MW-1:0]   mux_q, issue_sel;
  logic [DW-1:0]   wcs_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (slot_start) state_n = ARB;
      ARB:     state_n = ISSUE;
      ISSUE:   if (k_q == DW'(PORTS-1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Round-robin scan per output starting at its pointer; wrap handles non-power-of-2 PORTS.
  always_comb begin
    grant_n = '0;
    ptr_n   = ptr_q;
    for (int o = 0; o < PORTS; o++) begin : g_out
      logic          found;
      logic [DW:0]   sum;
      logic [DW-1:0] idx;
      found = 1'b0;
      for (int j = 0; j < PORTS; j++) begin
        sum = {1'b0, ptr_q[o]} + (DW+1)'(j);
        if (sum >= (DW+1)'(PORTS)) sum = sum - (DW+1)'(PORTS);
        idx = sum[DW-1:0];
        if (!found && req_q[idx] && (dest_q[idx] == DW'(o))) begin
          found        = 1'b1;
          grant_n[idx] = 1'b1;
          ptr_n[o]     = (idx == DW'(PORTS-1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign swdone    = (state == DONE);
  assign sw_valid  = (state == ISSUE) && grant[k_q];
  assign issue_sel = MW'(slot_q) * MW'(PORTS) + MW'(k_q);
  assign mux_sel   = sw_valid ? issue_sel  : mux_q;
  assign sw2op_wcs = sw_valid ? dest_q[k_q] : wcs_q;

  // NOTE: the latched request arrays are small, so they are reset along with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k_q         <= '0;
      slot_q      <= '0;
      req_q       <= '0;
      grant       <= '0;
      mux_q       <= '0;
      wcs_q       <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        dest_q[i] <= '0;
        ptr_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_n;
      err_overrun <= slot_start && (state != IDLE);
      mux_q       <= mux_sel;
      wcs_q       <= sw2op_wcs;
      case (state)
        IDLE: if (slot_start) begin
          slot_start_latch: begin
            slot_q <= running_slot;
            req_q  <= req;
            for (int i = 0; i < PORTS; i++) dest_q[i] <= req_dest[i*DW +: DW];
          end
        end
        ARB: begin
          grant <= grant_n;
          ptr_q <= ptr_n;
          k_q   <= '0;
        end
        ISSUE:   k_q <= k_q + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef XBAR_ARB_STATS_EN
  logic [DW:0]  n_valid, n_grant;
  logic [16:0]  cnt_sum;
  logic [15:0]  cnt_q;

  always_comb begin
    n_valid = '0;
    n_grant = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (req_q[i] && ({1'b0, dest_q[i]} < (DW+1)'(PORTS))) n_valid = n_valid + 1'b1;
      if (grant_n[i]) n_grant = n_grant + 1'b1;
    end
    cnt_sum = {1'b0, cnt_q} + 17'(n_valid - n_grant);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt_q <= '0;
    else if (state == ARB) cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
